// File: rtl/booth_pkg.sv
// Shared encodings for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StAdd   = 2'b01,
        StShift = 2'b10,
        StDone  = 2'b11
    } state_e;

    // {Q[0], q_m1} recoding pairs that modify the accumulator.
    localparam logic [1:0] PairSub = 2'b10;
    localparam logic [1:0] PairAdd = 2'b01;

endpackage

// File: rtl/booth_ctrl.sv
// Booth control FSM: sequences W+1 add/shift iterations and drives datapath strobes.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] pair,
    output logic       load,
    output logic       add_en,
    output logic       sub_en,
    output logic       shift_en,
    output logic       capture,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CW = $clog2(W + 1);

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic          last;

    assign last     = (count_q == CW'(W));
    assign load     = (state_q == StIdle) && start;
    assign add_en   = (state_q == StAdd) && (pair == PairAdd);
    assign sub_en   = (state_q == StAdd) && (pair == PairSub);
    assign shift_en = (state_q == StShift);
    assign capture  = shift_en && last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StAdd;
                        count_q <= '0;
                        busy    <= 1'b1;
                    end
                end
                StAdd: state_q <= StShift;
                StShift: begin
                    count_q <= count_q + CW'(1);
                    if (last) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else begin
                        state_q <= StAdd;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: W+1-bit A/Q/M datapath driven by booth_ctrl.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [W-1:0]   multiplicand,
    input  logic [W-1:0]   multiplier,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    logic [W:0]     a_q, q_q, m_q;
    logic           qm1_q;
    logic [2*W-1:0] product_q;
    logic [2*W+1:0] aq_sh;
    logic           load, add_en, sub_en, shift_en, capture;

    // Arithmetic right shift of {A,Q}; the bit leaving Q becomes q_m1.
    assign aq_sh   = {a_q[W], a_q, q_q[W:1]};
    assign product = product_q;

    booth_ctrl #(
        .W (W)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .pair     ({q_q[0], qm1_q}),
        .load     (load),
        .add_en   (add_en),
        .sub_en   (sub_en),
        .shift_en (shift_en),
        .capture  (capture),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            product_q <= '0;
        end else begin
            if (load) begin
                a_q   <= '0;
                m_q   <= {signed_mode & multiplicand[W-1], multiplicand};
                q_q   <= {signed_mode & multiplier[W-1], multiplier};
                qm1_q <= 1'b0;
            end else if (add_en) begin
                a_q <= a_q + m_q;
            end else if (sub_en) begin
                a_q <= a_q - m_q;
            end else if (shift_en) begin
                a_q   <= aq_sh[2*W+1:W+1];
                q_q   <= aq_sh[W:0];
                qm1_q <= q_q[0];
            end
            if (capture) begin
                product_q <= aq_sh[2*W-1:0];
            end
        end
    end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
Parametrised sequential radix-2 Booth multiplier with integrated control FSM and datapath. It generalises the fixed 3-bit, hard-coded-state Booth control unit to W-bit operands and a counter-driven iteration loop. It adds a signed/unsigned mode and a start/busy/done handshake, and sits as a multi-cycle arithmetic unit beside the datapath.

Parameters:
- W, 8, operand width in bits; must be at least 2.
- CW, $clog2(W+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a multiplication; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- multiplicand  in  W  operand M; sampled with start.
- multiplier  in  W  operand Q; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; product valid.
- product  out  2W  registered result; held until the next completion.

Interface (already decided):
- One clock, clk. Reset is synchronous and active-high, named reset.

Behaviour:
- Reset (edge with reset=1): state=IDLE, A=0, Q=0, M=0, q_m1=0, count=0, product=0. Therefore busy=0 and done=0.
- Reset has priority over all other inputs in every state, including mid-operation.
- Internal widths: A, M and Q are W+1 bits. Each operand is extended by one bit: sign-extended if signed_mode=1, zero-extended if signed_mode=0. This makes unsigned inputs non-negative in W+1-bit two's complement.
- States and transitions:
  - IDLE: if start=1, load M=ext(multiplicand), Q=ext(multiplier), A=0, q_m1=0, count=0, then go to ADD. Otherwise stay in IDLE.
  - ADD: act on {Q[0], q_m1}. For 10: A<=A-M. For 01: A<=A+M. For 00 or 11: A unchanged. Arithmetic is modulo 2^(W+1). Then go to SHIFT.
  - SHIFT: arithmetic right shift of {A,Q,q_m1} by 1 (A MSB replicated), count<=count+1.
    - If count==W (the last of W+1 iterations): product<={A,Q} shifted, low 2W bits, then go to DONE.
    - Otherwise go to ADD.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: call the start-sampling edge edge 0. DONE is entered at edge 2(W+1), so done is high for the cycle after that edge. For W=8 that is edge 18; for W=3 it is edge 8.
- Throughput: a new start is accepted in the first IDLE cycle after DONE. The minimum start-to-start interval is 2W+4 cycles.
- start while busy (ADD, SHIFT or DONE): ignored, not queued.
- Operand or mode changes after the sampling edge: no effect on the running operation.
- product changes only on entry to DONE (and on reset). It stays stable between completions.
- Range: the result always fits in 2W bits.
  - Unsigned max: (2^W-1)^2.
  - Signed extreme: (-2^(W-1))^2 = 2^(2W-2), which is positive and representable.
- start held high continuously: back-to-back operations, each with full latency.

Decomposition:
- Package booth_pkg holds:
  - state encoding: IDLE=2'b00, ADD=2'b01, SHIFT=2'b10, DONE=2'b11;
  - Booth pair constants: PAIR_SUB=2'b10, PAIR_ADD=2'b01.
- Sub-module booth_ctrl contains the FSM and iteration counter. It outputs load, add_en, sub_en, shift_en, capture and done, and takes {Q[0], q_m1} as input. It is the parametrised successor of the old control unit.
- Registers and adder/subtractor stay in booth_mul_seq.

Test Plan:
1. W=8, reset 2 cycles, then signed_mode=1, 3 × -2 (8'hFE) → done at edge 18, product=16'hFFFA. busy high on edges 1–19, busy=0 after.
2. W=8, 8'hFF × 8'hFF:
   - unsigned → 16'hFE01;
   - signed (-1 × -1) → 16'h0001.
3. W=8 signed:
   - -128 × -128 → 16'h4000;
   - -128 × 127 → 16'hC080;
   - 0 × 8'h80 → 16'h0000.
4. Start 5 × 7 unsigned. Keep start=1 and change operands to 9 × 9 at edge 4 → first done gives 16'h0023. Second done at edge 2·18+2 gives 16'h0051.
5. Assert reset at edge 9 mid-operation → next cycle busy=0, done=0, product=16'h0000. A new start of 12 × 12 unsigned then gives 16'h0090 with full latency.
6. W=3: all 64 operand pairs in both modes, checked against a behavioural model → latency 8 edges each; done is a single-cycle pulse every time.
